// File: rtl/serial_nibble_loader.sv
// serial_nibble_loader
//   Collects a framed serial bit stream into a WIDTH-bit word and holds it on
//   x_out behind a valid/ready handshake. This gives the downstream constant
//   comparator a stable X for as long as the word is held. Broken frames are
//   flagged and delivered words are counted.
//
// Parameters
//   WIDTH     : delivered word width (2..16).
//   MSB_FIRST : 1 = first serial bit of a frame ends up in x_out[WIDTH-1],
//               0 = first serial bit ends up in x_out[0].
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   sin_valid  : sin_bit / sin_start are valid this cycle
//   sin_bit    : serial data bit
//   sin_start  : marks the first bit of a frame
//   sin_ready  : loader accepts a serial bit this cycle (decoded from state only)
//   x_out      : assembled word, holds the last completed word
//   x_valid    : x_out holds a complete, undelivered word
//   x_ready    : consumer accepts x_out
//   frame_err  : one-cycle pulse when a partial frame is aborted by a new start
//   word_cnt   : delivered word count, wraps modulo 256
module serial_nibble_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_valid,
  input  logic             sin_bit,
  input  logic             sin_start,
  output logic             sin_ready,
  output logic [WIDTH-1:0] x_out,
  output logic             x_valid,
  input  logic             x_ready,
  output logic             frame_err,
  output logic [7:0]       word_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept;
  logic             deliver;
  logic             load;
  logic             abort;

  // Insert one serial bit into the word; direction fixes where bit 0 lands
  // once all WIDTH bits have been shifted in.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic              b);
    logic [WIDTH-1:0] res;
    if (MSB_FIRST) res = {cur[WIDTH-2:0], b};
    else           res = {b, cur[WIDTH-1:1]};
    return res;
  endfunction

  // sin_ready must not depend on x_ready, so it is a pure state decode.
  assign sin_ready = (state != HOLD);
  assign accept    = sin_valid & sin_ready;
  // x_valid is high exactly while in HOLD, so x_ready alone is ignored elsewhere.
  assign deliver   = x_valid & x_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    load      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        // Bits outside a frame are dropped until a start bit arrives.
        if (accept && sin_start) begin
          sr_nxt    = shift_in('0, sin_bit);
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          if (sin_start) begin
            // A new start inside a frame discards the partial word and
            // restarts the frame from this bit.
            abort   = 1'b1;
            sr_nxt  = shift_in('0, sin_bit);
            cnt_nxt = CW'(1);
          end else begin
            sr_nxt = shift_in(sr, sin_bit);
            if (cnt == LAST) begin
              load      = 1'b1;
              cnt_nxt   = '0;
              state_nxt = HOLD;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end
        end
      end
      HOLD: begin
        if (x_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      cnt       <= '0;
      x_out     <= '0;
      x_valid   <= 1'b0;
      frame_err <= 1'b0;
      word_cnt  <= 8'd0;
    end else begin
      sr        <= sr_nxt;
      cnt       <= cnt_nxt;
      frame_err <= abort;
      // x_out only changes when a frame completes; it keeps the last word
      // after the handshake.
      if (load) x_out <= sr_nxt;
      if (load)         x_valid <= 1'b1;
      else if (deliver) x_valid <= 1'b0;
      if (deliver) word_cnt <= word_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_serial_nibble_loader.sv
module tb_serial_nibble_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin_valid, sin_bit, sin_start;
  logic       x_ready;
  logic       sin_ready, x_valid, frame_err;
  logic [3:0] x_out;
  logic [7:0] word_cnt;
  logic       l_sin_ready, l_x_valid, l_frame_err;
  logic [3:0] l_x_out;
  logic [7:0] l_word_cnt;

  int tests  = 0;
  int fails  = 0;
  int errcnt = 0;

  always #5 clk = ~clk;

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .sin_start(sin_start), .sin_ready(sin_ready), .x_out(x_out),
    .x_valid(x_valid), .x_ready(x_ready), .frame_err(frame_err),
    .word_cnt(word_cnt)
  );

  serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .sin_start(sin_start), .sin_ready(l_sin_ready), .x_out(l_x_out),
    .x_valid(l_x_valid), .x_ready(x_ready), .frame_err(l_frame_err),
    .word_cnt(l_word_cnt)
  );

  // frame_err pulses seen on the MSB-first instance, sampled mid-cycle
  always @(negedge clk) if (frame_err) errcnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic s);
    sin_valid = 1'b1;
    sin_bit   = b;
    sin_start = s;
    tick();
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int e0;
    rst_n = 1'b0; sin_valid = 1'b0; sin_bit = 1'b0; sin_start = 1'b0; x_ready = 1'b1;
    tick();
    check("rst_x_out",     32'(x_out), 32'h0);
    check("rst_x_valid",   32'(x_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_word_cnt",  32'(word_cnt), 32'h0);
    check("rst_sin_ready", 32'(sin_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back 0(start),1,0,1 with x_ready high
    send(1'b0, 1'b1); send(1'b1, 1'b0); send(1'b0, 1'b0);
    check("t1_no_early_valid", 32'(x_valid), 32'h0);
    send(1'b1, 1'b0);
    check("t1_valid",      32'(x_valid), 32'h1);
    check("t1_x_out",      32'(x_out), 32'h5);
    check("t1_ready_hold", 32'(sin_ready), 32'h0);
    tick();
    check("t1_valid_drop", 32'(x_valid), 32'h0);
    check("t1_word_cnt",   32'(word_cnt), 32'h1);
    check("t1_no_err",     32'(errcnt), 32'h0);
    check("t1_ready_back", 32'(sin_ready), 32'h1);

    // 2: hold with x_ready low while serial input keeps toggling
    x_ready = 1'b0;
    send(1'b1, 1'b1); send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(x_valid), 32'h1);
      check("t2_hold_x_out", 32'(x_out), 32'hC);
      check("t2_sin_ready",  32'(sin_ready), 32'h0);
      sin_valid = i[0]; sin_bit = 1'b1; sin_start = 1'b1;
      tick();
    end
    sin_valid = 1'b0; sin_start = 1'b0;
    check("t2_still_valid", 32'(x_valid), 32'h1);
    check("t2_still_cnt",   32'(word_cnt), 32'h1);
    x_ready = 1'b1;
    tick();
    check("t2_delivered",  32'(x_valid), 32'h0);
    check("t2_word_cnt",   32'(word_cnt), 32'h2);
    check("t2_x_out_kept", 32'(x_out), 32'hC);
    send(1'b0, 1'b1); send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    check("t2_next_x_out", 32'(x_out), 32'h5);
    tick();
    check("t2_next_cnt",   32'(word_cnt), 32'h3);

    // 3: aborted frame
    e0 = errcnt;
    send(1'b1, 1'b1); send(1'b1, 1'b0);
    check("t3_err_before", 32'(frame_err), 32'h0);
    send(1'b0, 1'b1);
    check("t3_err_pulse",  32'(frame_err), 32'h1);
    check("t3_no_valid",   32'(x_valid), 32'h0);
    send(1'b1, 1'b0);
    check("t3_err_gone",   32'(frame_err), 32'h0);
    send(1'b0, 1'b0);
    check("t3_no_early",   32'(x_valid), 32'h0);
    send(1'b1, 1'b0);
    check("t3_valid",      32'(x_valid), 32'h1);
    check("t3_x_out",      32'(x_out), 32'h5);
    tick();
    check("t3_word_cnt",   32'(word_cnt), 32'h4);
    check("t3_err_count",  32'(errcnt - e0), 32'h1);

    // 4: stray bits in IDLE, then a gapped frame 1(start),0,1,0
    do_reset();
    e0 = errcnt;
    send(1'b1, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    check("t4_stray_ready", 32'(sin_ready), 32'h1);
    check("t4_stray_valid", 32'(x_valid), 32'h0);
    send(1'b1, 1'b1); tick();
    send(1'b0, 1'b0); tick(); tick();
    send(1'b1, 1'b0);
    sin_bit = 1'b1; tick();
    send(1'b0, 1'b0);
    check("t4_valid",      32'(x_valid), 32'h1);
    check("t4_x_out",      32'(x_out), 32'hA);
    check("t4_lsb_valid",  32'(l_x_valid), 32'h1);
    check("t4_lsb_x_out",  32'(l_x_out), 32'h5);
    tick();
    check("t4_word_cnt",   32'(word_cnt), 32'h1);
    check("t4_no_err",     32'(errcnt - e0), 32'h0);

    // 5: async reset mid-frame, no clock edge needed
    e0 = errcnt;
    send(1'b1, 1'b1); send(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_x_out", 32'(x_out), 32'h0);
    check("t5_async_valid", 32'(x_valid), 32'h0);
    check("t5_async_cnt",   32'(word_cnt), 32'h0);
    check("t5_async_ready", 32'(sin_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(1'b0, 1'b1); send(1'b1, 1'b0); send(1'b0, 1'b0);
    check("t5_no_early",   32'(x_valid), 32'h0);
    send(1'b1, 1'b0);
    check("t5_x_out",      32'(x_out), 32'h5);
    tick();
    check("t5_word_cnt",   32'(word_cnt), 32'h1);
    check("t5_no_err",     32'(errcnt - e0), 32'h0);

    // 6: word_cnt wraps after 255
    for (int n = 0; n < 254; n++) begin
      send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
      tick();
    end
    check("t6_cnt_255",    32'(word_cnt), 32'hFF);
    check("t6_lsb_cnt_255", 32'(l_word_cnt), 32'hFF);
    send(1'b1, 1'b1); send(1'b0, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    check("t6_x_out",      32'(x_out), 32'h9);
    tick();
    check("t6_cnt_wrap",   32'(word_cnt), 32'h0);
    check("t6_lsb_wrap",   32'(l_word_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
